// File: rtl/dm_bytelane_pkg.sv
// dm_pkg: shared definitions for the byte-lane data memory.
//   SZ_BYTE/SZ_HALF/SZ_WORD : access size encodings (2'b11 is illegal)
//   state_t                 : clear sequencer states
//   misaligned()            : true when size/lane combination cannot be served
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    // Illegal size counts as misaligned so a single check covers both.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lane[0];
            SZ_WORD: misaligned = |lane;
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_bytelane_if.sv
// dm_bytelane_if: MEM-stage access bus of the data memory.
//   Request side : req, we, addr, size, sign_ext, wd, pc (log only)
//   Response side: rd, rd_valid, busy, align_err
//   master modport drives requests, slave modport (the memory) drives responses.
interface dm_bytelane_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [31:0] rd;
    logic        rd_valid;
    logic        busy;
    logic        align_err;

    modport master (
        output req, we, addr, size, sign_ext, wd, pc,
        input  rd, rd_valid, busy, align_err
    );

    modport slave (
        input  req, we, addr, size, sign_ext, wd, pc,
        output rd, rd_valid, busy, align_err
    );

endinterface

// File: rtl/dm_bytelane_load_ext.sv
// dm_load_ext: combinational load lane select and extension.
//   word     : raw 32-bit memory word
//   lane     : addr[1:0], byte lane 0 = bits [7:0]
//   size     : access size (byte/half/word)
//   sign_ext : 1 = sign-extend, 0 = zero-extend (ignored for words)
//   ext      : right-aligned, extended 32-bit result
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: ext = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/dm_bytelane.sv
// dm_bytelane: byte/half/word data memory with registered read port and
// post-reset hardware clear.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : dm_bytelane_if.slave access port (see interface header)
// Parameters: DEPTH_LOG2 (log2 word count), BASE_ADDR (byte address of word 0).
module dm_bytelane
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    dm_bytelane_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    // Byte span of the array; 33 bits so the compare cannot overflow.
    localparam logic [32:0] SPAN  = 33'd4 << DEPTH_LOG2;

    logic [31:0] mem [DEPTH];

    state_t                state;
    state_t                state_next;
    logic [DEPTH_LOG2-1:0] clr_ptr;

    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            lane;
    logic                  bad;
    logic                  idle;
    logic                  do_store;
    logic                  do_load;
    logic                  reject;
    logic [31:0]           old_word;
    logic [31:0]           merged;
    logic [31:0]           load_val;
    logic                  unused_off_lo;

    // Unsigned offset: addresses below BASE_ADDR wrap high and fail the range check.
    assign off           = bus.addr - BASE_ADDR;
    assign idx           = off[DEPTH_LOG2+1:2];
    assign lane          = bus.addr[1:0];
    assign unused_off_lo = ^off[1:0];
    assign bad           = misaligned(bus.size, lane) || ({1'b0, off} >= SPAN);

    assign idle     = (state == ST_IDLE);
    assign do_store = idle & bus.req & bus.we & ~bad;
    assign do_load  = idle & bus.req & ~bus.we & ~bad;
    assign reject   = idle & bus.req & bad;
    assign bus.busy = (state == ST_CLEAR);

    assign old_word = mem[idx];

    // Replace only the addressed lanes of the current word.
    always_comb begin
        merged = old_word;
        case (bus.size)
            SZ_BYTE: merged[{lane, 3'b000} +: 8] = bus.wd[7:0];
            SZ_HALF: begin
                if (lane[1]) merged[31:16] = bus.wd[15:0];
                else         merged[15:0]  = bus.wd[15:0];
            end
            default: merged = bus.wd;
        endcase
    end

    dm_load_ext u_load_ext (
        .word     (old_word),
        .lane     (lane),
        .size     (bus.size),
        .sign_ext (bus.sign_ext),
        .ext      (load_val)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (clr_ptr == '1) state_next = ST_IDLE;
            ST_IDLE:  state_next = ST_IDLE;
            default:  state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_CLEAR;
            clr_ptr       <= '0;
            bus.rd        <= '0;
            bus.rd_valid  <= 1'b0;
            bus.align_err <= 1'b0;
        end else begin
            state         <= state_next;
            if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
            bus.rd_valid  <= do_load;
            bus.align_err <= reject;
            if (do_load) bus.rd <= load_val;
        end
    end

    // Array has no reset; the clear sequencer owns the write port while busy.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (do_store) begin
            mem[idx] <= merged;
`ifndef SYNTHESIS
            $display("@%h: *%h <= %h", bus.pc, {bus.addr[31:2], 2'b00}, merged);
`endif
        end
    end

endmodule

// File: tb/tb_dm_bytelane.sv
// tb_dm_bytelane: self-checking bench for dm_bytelane.
// A byte-array reference model (updated on every rising edge) predicts rd,
// rd_valid, align_err and busy; one compare process checks them on every
// falling edge. Directed sequences add literal expectations on top.
module tb_dm_bytelane;
    import dm_pkg::*;

    localparam int unsigned DEPTH_LOG2 = 10;
    localparam int unsigned WORDS      = 1 << DEPTH_LOG2;
    localparam int unsigned BYTES      = 4 * WORDS;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    dm_bytelane_if bus();

    dm_bytelane #(.DEPTH_LOG2(DEPTH_LOG2), .BASE_ADDR(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mem_b [BYTES];
    logic [31:0] m_rd;
    logic        m_valid;
    logic        m_err;
    int          clear_left;

    always @(posedge clk or posedge reset) begin
        int          nb;
        logic [31:0] off32;
        longint      v;
        if (reset) begin
            m_rd       = '0;
            m_valid    = 1'b0;
            m_err      = 1'b0;
            clear_left = WORDS;
            foreach (mem_b[i]) mem_b[i] = 8'h00;
        end else if (clear_left != 0) begin
            clear_left--;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (bus.req) begin
                nb    = (bus.size == 2'd0) ? 1 : (bus.size == 2'd1) ? 2 : (bus.size == 2'd2) ? 4 : 0;
                off32 = bus.addr - 32'h0000_0000;
                if (nb == 0 || (bus.addr % nb) != 0 || off32 >= BYTES) begin
                    m_err = 1'b1;
                end else if (bus.we) begin
                    for (int k = 0; k < nb; k++) mem_b[off32 + k] = bus.wd[8*k +: 8];
                end else begin
                    v = 0;
                    for (int k = 0; k < nb; k++) v += longint'(mem_b[off32 + k]) << (8 * k);
                    if (bus.sign_ext && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                        v -= longint'(1) << (8 * nb);
                    m_rd    = v[31:0];
                    m_valid = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("rd",        bus.rd,                  m_rd);
        check("rd_valid",  {31'b0, bus.rd_valid},   {31'b0, m_valid});
        check("align_err", {31'b0, bus.align_err},  {31'b0, m_err});
        check("busy",      {31'b0, bus.busy},       {31'b0, (clear_left != 0) || reset});
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic r, input logic w, input logic [1:0] s, input logic se,
                         input logic [31:0] a, input logic [31:0] d);
        bus.req      = r;
        bus.we       = w;
        bus.size     = s;
        bus.sign_ext = se;
        bus.addr     = a;
        bus.wd       = d;
        bus.pc       = 32'h0000_3000 + a;
    endtask

    task automatic idle_bus();
        drive(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    endtask

    // One request cycle; returns at the falling edge after the capturing edge.
    task automatic op(input logic w, input logic [1:0] s, input logic se,
                      input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, w, s, se, a, d);
        @(negedge clk);
        idle_bus();
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Async reset between edges: called at a falling edge, leaves reset released
    // at a later falling edge.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, "_rd0"},    bus.rd,                 32'h0);
        check({tag, "_valid0"}, {31'b0, bus.rd_valid},  32'h0);
        check({tag, "_err0"},   {31'b0, bus.align_err}, 32'h0);
        check({tag, "_busy1"},  {31'b0, bus.busy},      32'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int x;
        logic        r;
        logic        w;
        logic [1:0]  s;
        logic [31:0] a;

        idle_bus();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Load during clear is ignored; clear spans 1024 edges after release.
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        check("busy_load_valid", {31'b0, bus.rd_valid}, 32'h0);
        wait_clear(n);
        check("clear_len", n + 2, 1024);

        op(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        check("lw0_rd", bus.rd, 32'h0000_0000);
        check("lw0_valid", {31'b0, bus.rd_valid}, 32'h1);

        op(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344);
        op(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000_00AA);
        op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        check("sb_merge", bus.rd, 32'h1122_AA44);

        op(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000_80F0);
        op(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0);
        check("lh",  bus.rd, 32'hFFFF_80F0);
        op(1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0);
        check("lhu", bus.rd, 32'h0000_80F0);
        op(1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0);
        check("lb",  bus.rd, 32'hFFFF_FF80);
        op(1'b0, SZ_BYTE, 1'b0, 32'h22, 32'h0);
        check("lbu", bus.rd, 32'h0000_00F0);

        op(1'b0, SZ_WORD, 1'b0, 32'h2, 32'h0);
        check("rej_lw_err", {31'b0, bus.align_err}, 32'h1);
        check("rej_lw_valid", {31'b0, bus.rd_valid}, 32'h0);
        check("rej_lw_rdhold", bus.rd, 32'h0000_00F0);
        op(1'b1, SZ_HALF, 1'b0, 32'h5, 32'hFFFF_FFFF);
        check("rej_sh_err", {31'b0, bus.align_err}, 32'h1);
        op(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF);
        check("rej_sz3_err", {31'b0, bus.align_err}, 32'h1);
        op(1'b1, SZ_WORD, 1'b0, 32'h1000, 32'hFFFF_FFFF);
        check("rej_range_err", {31'b0, bus.align_err}, 32'h1);
        op(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        check("rej_mem_w0", bus.rd, 32'h0);
        op(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
        check("rej_mem_w1", bus.rd, 32'h0);

        drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hDEAD_BEEF);
        @(negedge clk);
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        check("raw_rd", bus.rd, 32'hDEAD_BEEF);
        check("b2b_v1", {31'b0, bus.rd_valid}, 32'h1);
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        check("b2b_v2", {31'b0, bus.rd_valid}, 32'h1);
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check("b2b_v3", {31'b0, bus.rd_valid}, 32'h1);
        check("b2b_rd3", bus.rd, 32'h1122_AA44);
        idle_bus();
        @(negedge clk);
        check("b2b_drop", {31'b0, bus.rd_valid}, 32'h0);

        // Reset mid-IDLE while a load result is being presented.
        op(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
        async_reset("rst_idle");
        wait_clear(n);
        check("clear_len_idle", n, 1024);

        // Reset 300 cycles into the clear.
        repeat (300) @(negedge clk);
        async_reset("rst_clear");
        wait_clear(n);
        check("clear_len_mid", n, 1024);
        op(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
        check("cleared_40", bus.rd, 32'h0);
        check("cleared_40_valid", {31'b0, bus.rd_valid}, 32'h1);

        // Randomized traffic in a small window so loads hit earlier stores.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            x = $urandom_range(0, 15);
            s = (x < 5) ? SZ_BYTE : (x < 10) ? SZ_HALF : (x < 15) ? SZ_WORD : 2'b11;
            x = $urandom_range(0, 19);
            if (x == 0)      a = 32'h0000_1000 + $urandom_range(0, 255);
            else if (x == 1) a = 32'hFFFF_FFFC;
            else             a = $urandom_range(0, 127);
            if ($urandom_range(0, 3) != 0) begin
                if (s == SZ_HALF) a[0] = 1'b0;
                if (s == SZ_WORD) a[1:0] = 2'b00;
            end
            drive(r, w, s, $urandom_range(0, 1) == 1, a, $urandom);
            @(negedge clk);
        end
        idle_bus();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
